snake_mover: RTL and testbench

SNAKE_MOVER -- requirements
Module: snake_mover

---
 rtl/snake_pkg.sv | 21 ++
 rtl/snake_tick_gen.sv | 27 ++
 rtl/snake_mover.sv | 104 ++++++++++
 tb/tb_snake_mover.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared types and widths for the snake mover: direction encoding and
// head/segment geometry.
package snake_pkg;

    localparam int COORD_W = 20;
    localparam int SEG_W   = 2 * COORD_W;
    localparam int SEG_N   = 5;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_RIGHT = 2'b01,
        DIR_DOWN  = 2'b10,
        DIR_LEFT  = 2'b11
    } dir_e;

    // Opposite directions differ only in the upper encoding bit.
    function automatic dir_e opposite(input dir_e d);
        return dir_e'(d ^ 2'b10);
    endfunction

endpackage

// File: rtl/snake_tick_gen.sv
// Move-step timebase: counts 0..TICK_DIV-1 and fires tick on terminal count.
// While freeze is high the count holds and no tick is produced.
module snake_tick_gen #(
    parameter int TICK_DIV = 25000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic freeze,
    output logic tick
);

    localparam int                CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == LAST) && !freeze;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!freeze) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/snake_mover.sv
// Snake head/body position tracker: steps the head once per tick in the
// latched direction with playfield wrap, shifting the body behind it.
module snake_mover
    import snake_pkg::*;
#(
    parameter int TICK_DIV = 25000000,
    parameter int STEP     = 10,
    parameter int X_MAX    = 640,
    parameter int Y_MAX    = 480,
    parameter int X_START  = 320,
    parameter int Y_START  = 240
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [1:0]             dir_req,
    input  logic                   dir_valid,
    input  logic                   pause,
    input  logic                   is_over,
    output logic [SEG_W-1:0]       head,
    output logic [SEG_N*SEG_W-1:0] body,
    output logic                   update
);

    localparam logic [COORD_W-1:0] STEP_C  = COORD_W'(STEP);
    localparam logic [COORD_W:0]   STEP_W  = (COORD_W+1)'(STEP);
    localparam logic [COORD_W:0]   X_MAX_W = (COORD_W+1)'(X_MAX);
    localparam logic [COORD_W:0]   Y_MAX_W = (COORD_W+1)'(Y_MAX);
    localparam logic [COORD_W-1:0] X_WRAP  = COORD_W'(X_MAX - STEP);
    localparam logic [COORD_W-1:0] Y_WRAP  = COORD_W'(Y_MAX - STEP);
    localparam logic [SEG_W-1:0]   HEAD_RST = {COORD_W'(X_START), COORD_W'(Y_START)};

    function automatic logic [SEG_N*SEG_W-1:0] body_init();
        logic [SEG_N*SEG_W-1:0] b;
        b = '0;
        for (int k = 0; k < SEG_N; k++) begin
            b[k*SEG_W +: SEG_W] = {COORD_W'(X_START - (k + 1) * STEP), COORD_W'(Y_START)};
        end
        return b;
    endfunction

    localparam logic [SEG_N*SEG_W-1:0] BODY_RST = body_init();

    logic               move;
    dir_e               dir_cur;
    dir_e               dir_pend;
    dir_e               dir_eff;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COORD_W:0]   x_sum;
    logic [COORD_W:0]   y_sum;
    logic [COORD_W-1:0] next_x;
    logic [COORD_W-1:0] next_y;

    snake_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .freeze (pause | is_over),
        .tick   (move)
    );

    assign x     = head[SEG_W-1:COORD_W];
    assign y     = head[COORD_W-1:0];
    assign x_sum = {1'b0, x} + STEP_W;
    assign y_sum = {1'b0, y} + STEP_W;

    // A reversal is judged against the direction that will be current after
    // this cycle, so a request landing on a move cycle sees the new heading.
    assign dir_eff = move ? dir_pend : dir_cur;

    always_comb begin
        next_x = x;
        next_y = y;
        case (dir_pend)
            DIR_UP:    next_y = (y < STEP_C) ? Y_WRAP : y - STEP_C;
            DIR_DOWN:  next_y = (y_sum >= Y_MAX_W) ? '0 : y_sum[COORD_W-1:0];
            DIR_RIGHT: next_x = (x_sum >= X_MAX_W) ? '0 : x_sum[COORD_W-1:0];
            DIR_LEFT:  next_x = (x < STEP_C) ? X_WRAP : x - STEP_C;
            default:   ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head     <= HEAD_RST;
            body     <= BODY_RST;
            update   <= 1'b0;
            dir_cur  <= DIR_RIGHT;
            dir_pend <= DIR_RIGHT;
        end else begin
            update <= move;
            if (move) begin
                head    <= {next_x, next_y};
                body    <= {body[(SEG_N-1)*SEG_W-1:0], head};
                dir_cur <= dir_pend;
            end
            if (dir_valid && (dir_req != opposite(dir_eff))) begin
                dir_pend <= dir_e'(dir_req);
            end
        end
    end

endmodule

// File: tb/tb_snake_mover.sv
// Scoreboard bench for snake_mover with a 4-clock tick: stimulus pushes the
// expected head/body per move, a monitor pops and compares on every update.
module tb_snake_mover;

    localparam int TICK_DIV = 4;
    localparam int STEP     = 10;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   dir_req;
    logic         dir_valid;
    logic         pause;
    logic         is_over;
    logic [39:0]  head;
    logic [199:0] body;
    logic         update;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [239:0] sb_q[$];
    logic [239:0] mon_e;

    logic [39:0]  m_head;
    logic [199:0] m_body;
    logic [1:0]   m_cur;
    logic [1:0]   m_pend;

    always #5 clk = ~clk;

    snake_mover #(
        .TICK_DIV (TICK_DIV),
        .STEP     (STEP),
        .X_MAX    (640),
        .Y_MAX    (480),
        .X_START  (320),
        .Y_START  (240)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .dir_req   (dir_req),
        .dir_valid (dir_valid),
        .pause     (pause),
        .is_over   (is_over),
        .head      (head),
        .body      (body),
        .update    (update)
    );

    function automatic logic [39:0] xy(input int x, input int y);
        return {x[19:0], y[19:0]};
    endfunction

    task automatic check(input string name, input logic [239:0] act, input logic [239:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_head = xy(320, 240);
        m_body = {xy(270, 240), xy(280, 240), xy(290, 240), xy(300, 240), xy(310, 240)};
        m_cur  = 2'd1;
        m_pend = 2'd1;
    endtask

    // Expected result of the next move, pushed onto the scoreboard.
    task automatic model_step();
        int x;
        int y;
        m_cur = m_pend;
        x = int'(m_head[39:20]);
        y = int'(m_head[19:0]);
        case (m_cur)
            2'd0: if (y >= 10) y = y - 10; else y = 470;
            2'd1: begin x = x + 10; if (x >= 640) x = 0; end
            2'd2: begin y = y + 10; if (y >= 480) y = 0; end
            default: if (x >= 10) x = x - 10; else x = 630;
        endcase
        m_body = {m_body[159:0], m_head};
        m_head = xy(x, y);
        sb_q.push_back({m_head, m_body});
    endtask

    task automatic wait_update(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!update && n < 12);
        if (!update) begin
            tests_run++;
            tests_failed++;
            $display("FAIL update_timeout: got no update after %0d cycles, required one", n);
        end
    endtask

    task automatic do_move();
        int n;
        model_step();
        wait_update(n);
    endtask

    task automatic set_dir(input logic [1:0] d);
        dir_req   = d;
        dir_valid = 1'b1;
        if (d != (m_cur ^ 2'b10)) m_pend = d;
        @(negedge clk);
        dir_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n && update) begin
            if (sb_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("FAIL unexpected_update: got update with head %0h, required no update", head);
            end else begin
                mon_e = sb_q.pop_front();
                check("move_head", {200'd0, head}, {200'd0, mon_e[239:200]});
                check("move_body", {40'd0, body}, {40'd0, mon_e[199:0]});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst_n     = 1'b0;
        dir_req   = 2'd0;
        dir_valid = 1'b0;
        pause     = 1'b0;
        is_over   = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);

        check("rst_head", head, xy(320, 240));
        check("rst_body", body, m_body);
        check("rst_update", update, 0);

        // First move with no inputs: rightward, four cycles after release.
        model_step();
        rst_n = 1'b1;
        wait_update(n);
        check("first_move_latency", n, 4);
        check("first_head", head, xy(330, 240));
        check("first_seg0", body[39:0], xy(320, 240));

        // Reversal request is ignored.
        set_dir(2'd3);
        do_move();
        check("reverse_ignored", head, xy(340, 240));
        do_move();

        // Reset mid-count after three moves.
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_head", head, xy(320, 240));
        check("midrst_body", body, {xy(270, 240), xy(280, 240), xy(290, 240), xy(300, 240), xy(310, 240)});
        check("midrst_update", update, 0);
        model_reset();
        repeat (2) @(negedge clk);
        model_step();
        rst_n = 1'b1;
        wait_update(n);
        check("post_reset_latency", n, 4);

        // Wrap on every edge of the playfield.
        set_dir(2'd0);
        repeat (25) do_move();
        check("up_wrap", head, xy(330, 470));
        set_dir(2'd1);
        repeat (31) do_move();
        check("right_wrap", head, xy(0, 470));
        set_dir(2'd2);
        do_move();
        check("down_wrap", head, xy(0, 0));
        set_dir(2'd3);
        do_move();
        check("left_wrap", head, xy(630, 0));

        // Pause mid-count holds the counter; the remainder completes after.
        @(negedge clk);
        pause = 1'b1;
        repeat (10) begin
            @(negedge clk);
            check("pause_no_update", update, 0);
        end
        pause = 1'b0;
        model_step();
        wait_update(n);
        check("pause_resume_latency", n, 3);

        // is_over raised in the move cycle blocks the move for good.
        repeat (3) @(negedge clk);
        is_over = 1'b1;
        repeat (12) begin
            @(negedge clk);
            check("over_no_update", update, 0);
            check("over_head_hold", head, m_head);
        end
        check("over_body_hold", body, m_body);
        check("scoreboard_drained", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
